// File: rtl/apmu_ibex_pkg.sv
// Shared PMU types: counter-bank request opcodes, PMC controller states
// and the architectural upper bound on the number of counters.
package apmu_ibex_pkg;

    localparam int unsigned PMC_MAX_COUNTERS = 32;

    typedef enum logic [1:0] {
        PMC_READ  = 2'd0,
        PMC_WRITE = 2'd1,
        PMC_CLEAR = 2'd2,
        PMC_NOP   = 2'd3
    } pmc_op_e;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_RD   = 2'd1,
        PMC_WB   = 2'd2
    } pmc_state_e;

endpackage

// File: rtl/apmu_pmc_counter.sv
// Single event counter: wrapping increment, 32-bit half writes, clear,
// and a sticky overflow flag raised on the all-ones to zero wrap.
// Software writes and clears take priority over a same-cycle event.
module apmu_pmc_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic             clr,
    input  logic [31:0]      wdata,
    output logic [Width-1:0] count,
    output logic             overflow
);

    // Counter and sticky wrap flag; software access beats the event strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[Width-1:32] <= wdata[Width-33:0];
        end else if (inc) begin
            count <= count + Width'(1);
            if (&count) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/apmu_pmc_unit.sv
// Performance-monitor counter bank with a small read controller that
// returns counter halves through a dedicated RF write port. The write only
// fires when the ID/LSU write sources are idle.
// Optional build macro: APMU_PMC_SHADOW_EN adds a shadow of the upper half
// captured on lower-half reads so a lo-then-hi read pair is torn-free.
//
// state    | meaning
// PMC_IDLE | ready for a request; WRITE/CLEAR applied at the next edge
// PMC_RD   | selected counter half registered into the result register
// PMC_WB   | result presented; write fires when the RF port is free
module apmu_pmc_unit
    import apmu_ibex_pkg::*;
#(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumCounters-1:0] event_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [4:0]             req_idx_i,
    input  logic                   req_hi_i,
    input  logic [31:0]            req_wdata_i,
    input  logic [4:0]             req_waddr_i,
    input  logic                   kill_i,
    input  logic                   rf_port_busy_i,
    output logic                   rf_we_pmc_o,
    output logic [31:0]            rf_wdata_pmc_o,
    output logic [4:0]             rf_waddr_pmc_o,
    output logic [NumCounters-1:0] overflow_o,
    output logic                   busy_o
);

    pmc_state_e state_q, state_d;
    pmc_op_e    op;
    logic       accept, rd_acc, wr_acc, clr_acc;

    logic [4:0]              idx_q;
    logic                    hi_q;
    logic [4:0]              waddr_q;
    logic [31:0]             res_q;
    logic [CounterWidth-1:0] cnt [NumCounters];
    logic [CounterWidth-1:0] sel;
    logic [31:0]             sel_hi;
    logic [31:0]             hi_val;

    assign op      = pmc_op_e'(req_op_i);
    assign accept  = req_valid_i & (state_q == PMC_IDLE);
    assign rd_acc  = accept & (op == PMC_READ);
    assign wr_acc  = accept & (op == PMC_WRITE);
    assign clr_acc = accept & (op == PMC_CLEAR);

    for (genvar i = 0; i < NumCounters; i++) begin : g_cnt
        logic hit;
        assign hit = (req_idx_i == 5'(i));
        apmu_pmc_counter #(.Width(CounterWidth)) u_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .inc      (event_i[i]),
            .wr_lo    (wr_acc & hit & ~req_hi_i),
            .wr_hi    (wr_acc & hit & req_hi_i),
            .clr      (clr_acc & hit),
            .wdata    (req_wdata_i),
            .count    (cnt[i]),
            .overflow (overflow_o[i])
        );
    end

    // Read mux: out-of-range indices fall through to zero.
    always_comb begin
        sel    = '0;
        sel_hi = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (idx_q == 5'(i)) begin
                sel = cnt[i];
            end
        end
        sel_hi[CounterWidth-33:0] = sel[CounterWidth-1:32];
    end

`ifdef APMU_PMC_SHADOW_EN
    logic [31:0] shadow_q;
    logic [4:0]  shadow_idx_q;
    logic        shadow_vld_q;
    logic        shadow_hit;

    assign shadow_hit = shadow_vld_q & (shadow_idx_q == idx_q);
    assign hi_val     = shadow_hit ? shadow_q : sel_hi;

    // Shadow capture on lo reads; dropped by unrelated reads or writes to the tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q     <= '0;
            shadow_idx_q <= '0;
            shadow_vld_q <= 1'b0;
        end else if (state_q == PMC_RD) begin
            if (!hi_q) begin
                shadow_q     <= sel_hi;
                shadow_idx_q <= idx_q;
                shadow_vld_q <= 1'b1;
            end else if (!shadow_hit) begin
                shadow_vld_q <= 1'b0;
            end
        end else if ((wr_acc | clr_acc) && (req_idx_i == shadow_idx_q)) begin
            shadow_vld_q <= 1'b0;
        end
    end
`else
    assign hi_val = sel_hi;
`endif

    // Latch the read request on accept and the selected half during RD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= '0;
            hi_q    <= 1'b0;
            waddr_q <= '0;
            res_q   <= '0;
        end else begin
            if (rd_acc) begin
                idx_q   <= req_idx_i;
                hi_q    <= req_hi_i;
                waddr_q <= req_waddr_i;
            end
            if (state_q == PMC_RD) begin
                res_q <= hi_q ? hi_val : sel[31:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PMC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: kill aborts RD/WB; WB waits for a free RF port.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PMC_IDLE: if (rd_acc) state_d = PMC_RD;
            PMC_RD:   state_d = kill_i ? PMC_IDLE : PMC_WB;
            PMC_WB: begin
                if (kill_i || (waddr_q == 5'd0) || !rf_port_busy_i) begin
                    state_d = PMC_IDLE;
                end
            end
            default:  state_d = PMC_IDLE;
        endcase
    end

    // Outputs: RF result visible only in WB, write gated by port and kill.
    always_comb begin
        req_ready_o    = (state_q == PMC_IDLE);
        busy_o         = (state_q != PMC_IDLE);
        rf_we_pmc_o    = 1'b0;
        rf_wdata_pmc_o = '0;
        rf_waddr_pmc_o = '0;
        if (state_q == PMC_WB) begin
            rf_wdata_pmc_o = res_q;
            rf_waddr_pmc_o = waddr_q;
            rf_we_pmc_o    = ~rf_port_busy_i & ~kill_i & (waddr_q != 5'd0);
        end
    end

endmodule

// File: tb/tb_apmu_pmc_unit.sv
// Scoreboard bench for apmu_pmc_unit: expected RF writes are queued when a
// READ is issued and popped by a monitor whenever rf_we_pmc_o fires.
module tb_apmu_pmc_unit;

    localparam int NC = 8;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] event_v;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [4:0]    req_idx;
    logic          req_hi;
    logic [31:0]   req_wdata;
    logic [4:0]    req_waddr;
    logic          kill;
    logic          rf_port_busy;
    logic          rf_we;
    logic [31:0]   rf_wdata;
    logic [4:0]    rf_waddr;
    logic [NC-1:0] overflow;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    apmu_pmc_unit #(.NumCounters(NC), .CounterWidth(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .event_i        (event_v),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_idx_i      (req_idx),
        .req_hi_i       (req_hi),
        .req_wdata_i    (req_wdata),
        .req_waddr_i    (req_waddr),
        .kill_i         (kill),
        .rf_port_busy_i (rf_port_busy),
        .rf_we_pmc_o    (rf_we),
        .rf_wdata_pmc_o (rf_wdata),
        .rf_waddr_pmc_o (rf_waddr),
        .overflow_o     (overflow),
        .busy_o         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every RF write must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        logic [36:0] e;
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            check("we_with_port_busy", rf_port_busy, 0);
            if (sb.size() == 0) begin
                check("unexpected_we", rf_we, 0);
            end else begin
                e = sb.pop_front();
                check("wb_waddr", rf_waddr, e[36:32]);
                check("wb_wdata", rf_wdata, e[31:0]);
            end
        end
    end

    task automatic ev(input logic [NC-1:0] mask, input int n);
        @(posedge clk); #1;
        event_v = mask;
        repeat (n) @(posedge clk);
        #1;
        event_v = '0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [4:0] idx, input logic hi, input logic [31:0] d);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_idx = idx; req_hi = hi; req_wdata = d;
        @(negedge clk);
        check("wr_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] idx, input logic hi, input logic [4:0] wa,
                      input logic [31:0] exp, input int busy_n);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd0; req_idx = idx; req_hi = hi; req_waddr = wa;
        @(negedge clk);
        check("rd_accept_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        rf_port_busy = (busy_n > 0);
        if (wa != 5'd0) sb.push_back({wa, exp});
        @(negedge clk);
        check("rd_busy", busy, 1);
        check("rd_no_we", rf_we, 0);
        for (int k = 0; k < busy_n; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("wb_blocked", rf_we, 0);
            check("wb_hold_data", rf_wdata, exp);
            check("wb_hold_addr", rf_waddr, wa);
        end
        @(posedge clk); #1;
        rf_port_busy = 1'b0;
        @(negedge clk);
        check("wb_fire", rf_we, (wa != 5'd0));
        @(posedge clk); #1;
        @(negedge clk);
        check("post_ready", req_ready, 1);
        check("post_busy", busy, 0);
    endtask

    task automatic rd_kill(input logic in_wb);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd0; req_idx = 5'd2; req_hi = 1'b0; req_waddr = 5'd5;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        kill      = !in_wb;
        @(negedge clk);
        check("kill_rd_no_we", rf_we, 0);
        if (in_wb) begin
            @(posedge clk); #1;
            kill = 1'b1;
            @(negedge clk);
            check("kill_wb_no_we", rf_we, 0);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_ready", req_ready, 1);
        check("kill_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; event_v = '0; req_valid = 1'b0; req_op = 2'd0; req_idx = '0;
        req_hi = 1'b0; req_wdata = '0; req_waddr = '0; kill = 1'b0; rf_port_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_we", rf_we, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        // Basic read of an event count.
        ev(8'h04, 5);
        rd(5'd2, 1'b0, 5'd7, 32'd5, 0);

        // Wrap and sticky overflow, cleared by CLEAR.
        wr(2'd1, 5'd0, 1'b1, 32'hFFFF_FFFF);
        wr(2'd1, 5'd0, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("ovf_before_wrap", overflow[0], 0);
        ev(8'h01, 1);
        @(negedge clk);
        check("ovf_after_wrap", overflow[0], 1);
        rd(5'd0, 1'b0, 5'd4, 32'd0, 0);
        rd(5'd0, 1'b1, 5'd4, 32'd0, 0);
        wr(2'd2, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("ovf_after_clear", overflow[0], 0);

        // RF port contention in WB.
        rd(5'd2, 1'b0, 5'd9, 32'd5, 3);

        // Kill in RD and in WB.
        rd_kill(1'b0);
        rd_kill(1'b1);

        // Write beats same-cycle event; out-of-range read; waddr 0.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd1; req_idx = 5'd1; req_hi = 1'b0; req_wdata = 32'd10;
        event_v = 8'h02;
        @(posedge clk); #1;
        req_valid = 1'b0; event_v = '0;
        rd(5'd1, 1'b0, 5'd3, 32'd10, 0);
        wr(2'd1, 5'd20, 1'b0, 32'h1234);
        rd(5'd20, 1'b0, 5'd11, 32'd0, 0);
        rd(5'd20, 1'b1, 5'd11, 32'd0, 0);
        rd(5'd1, 1'b0, 5'd0, 32'd10, 0);

        // Lo/hi read pair across an upper-half carry.
        wr(2'd1, 5'd3, 1'b1, 32'd1);
        wr(2'd1, 5'd3, 1'b0, 32'hFFFF_FFFF);
        rd(5'd3, 1'b0, 5'd12, 32'hFFFF_FFFF, 0);
        ev(8'h08, 1);
`ifdef APMU_PMC_SHADOW_EN
        rd(5'd3, 1'b1, 5'd13, 32'd1, 0);
`else
        rd(5'd3, 1'b1, 5'd13, 32'd2, 0);
`endif
        rd(5'd3, 1'b0, 5'd14, 32'd0, 0);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apmu_pmc_unit.md
Name: apmu_pmc_unit

Overview:
Performance-monitor counter bank for the PMU core. It counts hardware events and serves counter read and write requests issued from ID/EX. Read results are delivered as a dedicated register-file write source, rf_we_pmc_o/rf_wdata_pmc_o/rf_waddr_pmc_o, which the writeback stage consumes. A result is only written back in cycles where the ID and LSU write sources are idle, so at most one RF write source is active per cycle.

Parameters:
NumCounters, 8, number of event counters (1..32)
CounterWidth, 64, counter width in bits (33..64)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
event_i  in  NumCounters  per-counter increment strobe, one increment per cycle when high
req_valid_i  in  1  request valid from ID/EX
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  2  operation: 0=READ, 1=WRITE, 2=CLEAR, 3=reserved (treated as no-op)
req_idx_i  in  5  counter index
req_hi_i  in  1  select upper half (bits CounterWidth-1:32); otherwise lower 32 bits
req_wdata_i  in  32  write data for WRITE
req_waddr_i  in  5  destination RF register for READ
kill_i  in  1  flush: abort any in-flight READ
rf_port_busy_i  in  1  ID or LSU RF write active this cycle
rf_we_pmc_o  out  1  RF write enable
rf_wdata_pmc_o  out  32  RF write data
rf_waddr_pmc_o  out  5  RF write address
overflow_o  out  NumCounters  sticky per-counter wrap flags
busy_o  out  1  a READ is in flight

Behaviour:
- Reset: all counters, overflow_o, rf_we_pmc_o, rf_wdata_pmc_o, rf_waddr_pmc_o, busy_o and the shadow register clear to 0. FSM goes to IDLE, so req_ready_o=1.
- FSM states:
  - IDLE: req_ready_o=1. An accepted READ goes to RD. An accepted WRITE/CLEAR takes effect at the next edge and the FSM stays in IDLE.
  - RD: the selected half is registered into the result register. Always lasts 1 cycle, then goes to WB.
  - WB: rf_we_pmc_o = ~rf_port_busy_i & (waddr != 0). Return to IDLE in the cycle the write fires, or immediately when waddr=0 (no write). Otherwise stay in WB.
- Ready and busy: req_ready_o=0 in RD and WB. busy_o=1 in RD and WB.
- Latency: READ minimum is accept, then 2 cycles to rf_we_pmc_o. Back-to-back READ throughput is one per 3 cycles.
- rf_wdata_pmc_o/rf_waddr_pmc_o: hold their value while in WB and are 0 otherwise.
- kill_i: in RD or WB, return to IDLE with no RF write, including in the same cycle rf_we would have fired (kill wins). Ignored in IDLE.
- Counting: counter[i] += 1 when event_i[i]=1, wrapping modulo 2^CounterWidth. On a wrap from all-ones to 0, overflow_o[i] is set. It is cleared only by CLEAR of that counter or by reset.
- WRITE, req_hi_i=0: sets bits 31:0 to req_wdata_i.
- WRITE, req_hi_i=1: sets upper bits to req_wdata_i[CounterWidth-33:0].
- CLEAR: zeroes the whole counter and its overflow flag.
- Same-cycle write and event: WRITE/CLEAR wins over an event increment on the same counter.
- Out-of-range index: an index >= NumCounters reads as 0. WRITE/CLEAR to it is ignored.
- Read width: upper-half reads are zero-extended to 32 bits.
- READ sampling: the value is sampled at the RD edge, i.e. it includes events up to and including the accept cycle.

Optional Feature:
APMU_PMC_SHADOW_EN
- Defined: a lower-half READ also captures that counter's upper half into a shadow register tagged with the index.
  - A following upper-half READ of the same index returns the shadow value, giving a torn-free 64-bit read.
  - Any other READ, or a WRITE/CLEAR to the tagged index, invalidates the tag.
- Not defined: upper-half reads return the live upper bits and no shadow register exists.

Decomposition:
- Shared package apmu_ibex_pkg gets:
  - pmc_op_e (PMC_READ, PMC_WRITE, PMC_CLEAR, PMC_NOP)
  - pmc_state_e (PMC_IDLE, PMC_RD, PMC_WB)
  - PMC_MAX_COUNTERS=32
- Sub-module apmu_pmc_counter: one counter with increment, half-write, clear and sticky overflow, instantiated NumCounters times.
- The FSM, read mux and shadow register stay in the top level.

Test Plan:
1. Reset, pulse event_i[2] 5 cycles, READ idx2 lo waddr=7 with rf_port_busy_i=0 -> rf_we_pmc_o=1 exactly 2 cycles after accept, wdata=5, waddr=7, then req_ready_o=1.
2. WRITE idx0 hi=0xFFFFFFFF and lo=0xFFFFFFFF, then one event_i[0] -> counter=0, overflow_o[0]=1. CLEAR idx0 -> overflow_o[0]=0.
3. READ with rf_port_busy_i held 3 cycles in WB -> rf_we_pmc_o stays 0 for those 3 cycles, fires in cycle 4 with unchanged data, and is never high in the same cycle as rf_port_busy_i.
4. kill_i asserted in RD, and separately in WB -> no RF write, FSM back in IDLE next cycle, busy_o=0.
5. Same-cycle WRITE idx1=10 and event_i[1] -> counter=10. READ idx=20 with NumCounters=8 -> wdata=0. READ with waddr=0 -> no write, back to IDLE.
6. With APMU_PMC_SHADOW_EN: counter=0x1_FFFFFFFF, READ lo, 1 event, READ hi -> hi=1. Without the macro -> hi=2.
